// File: rtl/fpadd_pkg.sv
// Shared types and defaults for the two-port FP32 adder arbiter.
package fpadd_pkg;

    localparam int FP32_W    = 32;
    localparam int NPORTS    = 2;
    localparam int LAT_DEF   = 3;
    localparam int DEPTH_DEF = 4;

    // Travels alongside each issued operation so its sum can be routed home.
    typedef struct packed {
        logic valid;
        logic port;
    } tag_t;

endpackage

// File: rtl/fpadd_result_fifo.sv
// Show-ahead result FIFO; pop_data reads as zero while the FIFO is empty.
module fpadd_result_fifo
    import fpadd_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [FP32_W-1:0] push_data,
    input  logic              pop,
    output logic [FP32_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [FP32_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop & ~empty;
    // A push into a full FIFO is fine when the head leaves on the same edge.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fpadd_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined FP32 adder between two
// requesters, with credit-limited per-port result FIFOs so the adder never stalls.
module fpadd_arbiter
    import fpadd_pkg::*;
#(
    parameter int LAT   = LAT_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic [FP32_W-1:0] req_a_0,
    input  logic [FP32_W-1:0] req_b_0,
    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic [FP32_W-1:0] req_a_1,
    input  logic [FP32_W-1:0] req_b_1,
    output logic              res_valid_0,
    input  logic              res_ready_0,
    output logic [FP32_W-1:0] res_data_0,
    output logic              res_valid_1,
    input  logic              res_ready_1,
    output logic [FP32_W-1:0] res_data_1,
    output logic [FP32_W-1:0] add_a,
    output logic [FP32_W-1:0] add_b,
    input  logic [FP32_W-1:0] add_out,
    output logic              idle
);

    localparam int CW = $clog2(DEPTH + 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. Ready may look at both valids; valid must never look at ready.

    logic [CW-1:0] out_0;
    logic [CW-1:0] out_1;
    logic          ok_0, ok_1;
    logic          cand_0, cand_1;
    logic          grant_0, grant_1;
    logic          accept;
    logic          gport;
    logic          rr;
    logic          pop_0, pop_1;
    logic          push_0, push_1;
    logic          empty_0, empty_1;
    logic          full_0, full_1;
    tag_t          issue_tag;
    tag_t          tag_pipe [LAT];

    assign ok_0   = (out_0 < CW'(DEPTH));
    assign ok_1   = (out_1 < CW'(DEPTH));
    assign cand_0 = req_valid_0 & ok_0;
    assign cand_1 = req_valid_1 & ok_1;

    // rr remembers the last tie winner; the other port wins the next tie.
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (cand_0 && cand_1) begin
            grant_0 = rr;
            grant_1 = ~rr;
        end else begin
            grant_0 = cand_0;
            grant_1 = cand_1;
        end
    end

    assign accept      = grant_0 | grant_1;
    assign gport       = grant_1;
    assign req_ready_0 = grant_0 & reset;
    assign req_ready_1 = grant_1 & reset;

    assign pop_0 = res_valid_0 & res_ready_0;
    assign pop_1 = res_valid_1 & res_ready_1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr    <= 1'b1;
            out_0 <= '0;
            out_1 <= '0;
        end else begin
            if (cand_0 && cand_1) begin
                rr <= gport;
            end
            case ({grant_0, pop_0})
                2'b10:   out_0 <= out_0 + CW'(1);
                2'b01:   out_0 <= out_0 - CW'(1);
                default: out_0 <= out_0;
            endcase
            case ({grant_1, pop_1})
                2'b10:   out_1 <= out_1 + CW'(1);
                2'b01:   out_1 <= out_1 - CW'(1);
                default: out_1 <= out_1;
            endcase
        end
    end

    // issue_tag is registered with add_a/add_b; the LAT stages behind it line
    // up with the cycle in which add_out holds that operation's sum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            add_a     <= '0;
            add_b     <= '0;
            issue_tag <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            issue_tag <= '{valid: accept, port: gport};
            if (accept) begin
                add_a <= gport ? req_a_1 : req_a_0;
                add_b <= gport ? req_b_1 : req_b_0;
            end
            tag_pipe[0] <= issue_tag;
            for (int i = 1; i < LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign push_0 = tag_pipe[LAT-1].valid & ~tag_pipe[LAT-1].port;
    assign push_1 = tag_pipe[LAT-1].valid &  tag_pipe[LAT-1].port;

    fpadd_result_fifo #(.DEPTH(DEPTH)) u_fifo_0 (
        .clk       (clk),
        .reset     (reset),
        .push      (push_0),
        .push_data (add_out),
        .pop       (res_ready_0),
        .pop_data  (res_data_0),
        .full      (full_0),
        .empty     (empty_0)
    );

    fpadd_result_fifo #(.DEPTH(DEPTH)) u_fifo_1 (
        .clk       (clk),
        .reset     (reset),
        .push      (push_1),
        .push_data (add_out),
        .pop       (res_ready_1),
        .pop_data  (res_data_1),
        .full      (full_1),
        .empty     (empty_1)
    );

    assign res_valid_0 = ~empty_0;
    assign res_valid_1 = ~empty_1;
    assign idle        = (out_0 == '0) & (out_1 == '0);

    // Credits make a write into a full FIFO without a pop impossible.
    no_overflow_0: assert property (@(posedge clk) disable iff (!reset)
        !(push_0 && full_0 && !pop_0));
    no_overflow_1: assert property (@(posedge clk) disable iff (!reset)
        !(push_1 && full_1 && !pop_1));

endmodule
